// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: cache, then video-IO, then CPU.
// Any lock loss or restart request drops every domain back into reset.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int COUNT_W            = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    input  logic               restart_req,
    output logic               reset_cache,
    output logic               reset_vio,
    output logic               reset_cpu,
    output logic               system_ready,
    output logic [COUNT_W-1:0] lock_loss_count,
    output logic [2:0]         seq_state
);
    localparam int MAX_DWELL = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        REL_CACHE = 3'd2,
        REL_VIO   = 3'd3,
        RUN       = 3'd4
    } seqStateT;

    seqStateT         state;
    logic [CNT_W-1:0] dwellCnt;
    logic             sync1;
    logic             lockedS;

    // Output pattern {reset_cache, reset_vio, reset_cpu, system_ready} for a state.
    function automatic logic [3:0] releaseMap(input seqStateT s);
        case (s)
            REL_CACHE: releaseMap = 4'b0110;
            REL_VIO:   releaseMap = 4'b0010;
            RUN:       releaseMap = 4'b0001;
            default:   releaseMap = 4'b1110;
        endcase
    endfunction

    assign seq_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1           <= 1'b0;
            lockedS         <= 1'b0;
            state           <= WAIT_LOCK;
            dwellCnt        <= '0;
            lock_loss_count <= '0;
            {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(WAIT_LOCK);
        end else begin
            sync1   <= locked;
            lockedS <= sync1;
            if (!lockedS && state != WAIT_LOCK) begin
                // A simultaneous restart request lands here too, so it counts once.
                state    <= WAIT_LOCK;
                dwellCnt <= '0;
                {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(WAIT_LOCK);
                if (lock_loss_count != {COUNT_W{1'b1}})
                    lock_loss_count <= lock_loss_count + 1'b1;
            end else if (restart_req) begin
                state    <= WAIT_LOCK;
                dwellCnt <= '0;
                {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(WAIT_LOCK);
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        if (lockedS) begin
                            state    <= STABILIZE;
                            dwellCnt <= '0;
                            {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(STABILIZE);
                        end
                    end
                    STABILIZE: begin
                        if (dwellCnt == STABLE_LAST) begin
                            state    <= REL_CACHE;
                            dwellCnt <= '0;
                            {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(REL_CACHE);
                        end else begin
                            dwellCnt <= dwellCnt + 1'b1;
                        end
                    end
                    REL_CACHE: begin
                        if (dwellCnt == GAP_LAST) begin
                            state    <= REL_VIO;
                            dwellCnt <= '0;
                            {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(REL_VIO);
                        end else begin
                            dwellCnt <= dwellCnt + 1'b1;
                        end
                    end
                    REL_VIO: begin
                        if (dwellCnt == GAP_LAST) begin
                            state    <= RUN;
                            dwellCnt <= '0;
                            {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(RUN);
                        end else begin
                            dwellCnt <= dwellCnt + 1'b1;
                        end
                    end
                    RUN: begin
                    end
                    default: begin
                        state    <= WAIT_LOCK;
                        dwellCnt <= '0;
                        {reset_cache, reset_vio, reset_cpu, system_ready} <= releaseMap(WAIT_LOCK);
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumes the ECP5 PLL `locked` output and produces staged, synchronous reset releases for the cache, video-IO and CPU domains.
- Holds every downstream reset asserted until lock has been stable for a programmable time, then releases in the order cache → VIO → CPU.
- Re-asserts all resets on loss of lock or on an external restart request.
- Keeps a saturating count of lock-loss events for debug.

Parameters:
- LOCK_STABLE_CYCLES, 1024, cycles `locked_s` must remain high before the first release (≥2).
- STAGE_GAP, 16, cycles between successive domain releases (≥1).
- COUNT_W, 8, width of the lock-loss counter.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- locked  in  1  PLL lock, asynchronous to `clock`; double-flop synchronised internally.
- restart_req  in  1  synchronous request to rerun the full sequence.
- reset_cache  out  1  active-high reset for the instruction-cache domain.
- reset_vio  out  1  active-high reset for the video-IO domain.
- reset_cpu  out  1  active-high reset for the CPU domain.
- system_ready  out  1  high only in RUN.
- lock_loss_count  out  COUNT_W  saturating count of lock losses.
- seq_state  out  3  current FSM state encoding, for debug.

Behaviour:
- **Synchroniser:** `locked` → sync1 → sync2 (`locked_s`). Two-cycle latency. Both flops clear on `reset`.
- **States and encodings:** WAIT_LOCK=0, STABILIZE=1, REL_CACHE=2, REL_VIO=3, RUN=4. Codes 5–7 are illegal and go to WAIT_LOCK on the next edge.
- **Output registration:** all outputs are registered and change on the same edge as the state.
  - `reset_cache` = 0 in REL_CACHE, REL_VIO and RUN.
  - `reset_vio` = 0 in REL_VIO and RUN.
  - `reset_cpu` = 0 in RUN only.
  - `system_ready` = 1 in RUN only.
- **Reset values:** `state` = WAIT_LOCK, all three resets = 1, `system_ready` = 0, `lock_loss_count` = 0, internal counter = 0.
- **WAIT_LOCK:** if `locked_s`=1 and `restart_req`=0, go to STABILIZE with counter=0.
- **STABILIZE:**
  - Counter increments each cycle.
  - When counter == LOCK_STABLE_CYCLES-1, go to REL_CACHE with counter=0.
  - Dwell in STABILIZE is exactly LOCK_STABLE_CYCLES cycles.
- **REL_CACHE / REL_VIO:** each dwells exactly STAGE_GAP cycles using the same counter, then advances to REL_VIO / RUN.
- **RUN:** holds indefinitely.
- **Priority, evaluated each edge:**
  1. `reset`.
  2. `locked_s`=0 in any state other than WAIT_LOCK: go to WAIT_LOCK, all resets re-assert on that edge, `lock_loss_count`+1, saturating at 2^COUNT_W-1.
  3. `restart_req`=1 in any state: go to WAIT_LOCK, count unchanged.
  4. Normal progression.
- **Simultaneous events:**
  - Lock loss together with `restart_req` counts once.
  - `locked_s`=0 while in WAIT_LOCK is not counted.
  - `restart_req` held high keeps the FSM in WAIT_LOCK.
- **Counter width:** sized to max(LOCK_STABLE_CYCLES, STAGE_GAP). It never wraps inside a state, because exit occurs at terminal count.
- **Reset mid-sequence:** from any state, `reset` returns to WAIT_LOCK on the next edge; the synchroniser is also cleared, so the 2-cycle sync latency reapplies.
- **Lock glitches:** a glitch on `locked` shorter than one clock may be missed. Any glitch sampled by the synchroniser restarts the sequence.

Test Plan (LOCK_STABLE_CYCLES=8, STAGE_GAP=4, COUNT_W=8; edges numbered from the first edge sampling `locked`=1):
1. **Power-up sequence.** Release `reset`, raise `locked` before edge 0 and hold.
   - STABILIZE at edge 2.
   - `reset_cache`=0 at edge 10.
   - `reset_vio`=0 at edge 14.
   - `reset_cpu`=0 and `system_ready`=1 at edge 18.
   - All resets = 1 at every earlier edge; `lock_loss_count`=0.
2. **Lock loss in RUN.** From RUN, drop `locked` for 5 cycles.
   - All resets = 1 and `system_ready`=0 two edges after the drop (sync latency).
   - `lock_loss_count`=1.
   - Re-raising `locked` repeats scenario 1 timing.
3. **Lock loss mid-sequence.** Drop `locked` during REL_CACHE.
   - `reset_cache` returns to 1, `reset_cpu` stays 1, count increments.
4. **Restart request.** Pulse `restart_req` for 1 cycle in RUN while locked.
   - Next edge: WAIT_LOCK, all resets = 1, count unchanged.
   - STABILIZE follows on the next edge, then releases at +8/+12/+16 cycles relative to STABILIZE entry.
5. **Counter saturation and reset clear.** Force 300 lock-loss events.
   - `lock_loss_count`=255 and holds.
   - Assert `reset` → count=0, `seq_state`=0.
6. **Simultaneous events.** Assert `restart_req` on the same edge `locked_s` falls in REL_VIO → count +1 exactly once.
   - Assert `reset` with `restart_req` and `locked` active → state WAIT_LOCK, count=0.
